// File: rtl/noc_dev_rx_framer.sv
// Device-side receive framer: delineates command/destination/payload frames from the NOC link
// and stores them in a commit/rollback FIFO so the device only ever sees complete frames.
module noc_dev_rx_framer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          noc_to_dev_ctl,
  input  logic [7:0]    noc_to_dev_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_first,
  output logic          out_last,
  output logic          frame_drop,
  output logic          frame_abort,
  output logic          stray_byte,
  output logic          busy,
  output logic [AW:0]   fill_level
);

  typedef enum logic [1:0] {S_IDLE, S_DEST, S_PAYLOAD, S_DROP} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [5:0]    count_q, count_d;
  logic [4:0]    n_q, n_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   wr_spec_q, wr_spec_d;
  logic [AW:0]   wr_commit_q, wr_commit_d;
  logic          drop_q, drop_d;
  logic          abort_q, abort_d;
  logic          stray_q, stray_d;

  // Entry layout: {first, last, data[7:0]}
  logic [9:0]    mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [9:0]    wdata;

  logic [9:0]    head;
  logic          pop;
  logic [2:0]    opcode;
  logic [4:0]    len;
  logic          idle_proc;
  logic [AW:0]   base;
  logic [AW:0]   free;
  logic [AW:0]   need;

  assign opcode = noc_to_dev_data[7:5];
  assign len    = noc_to_dev_data[4:0];

  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign out_valid  = (wr_commit_q != rd_ptr_q);
  assign pop        = out_valid & out_ready;
  assign out_data   = out_valid ? head[7:0] : 8'h00;
  assign out_first  = out_valid & head[9];
  assign out_last   = out_valid & head[8];
  assign fill_level = wr_commit_q - rd_ptr_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_drop  = drop_q;
  assign frame_abort = abort_q;
  assign stray_byte  = stray_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    n_d         = n_q;
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    drop_d      = 1'b0;
    abort_d     = 1'b0;
    stray_d     = 1'b0;
    we          = 1'b0;
    waddr       = wr_spec_q[AW-1:0];
    wdata       = '0;
    idle_proc   = 1'b0;
    base        = wr_spec_q;
    free        = '0;
    need        = '0;

    case (state_q)
      S_IDLE: idle_proc = 1'b1;
      S_DEST: begin
        if (noc_to_dev_ctl) begin
          abort_d   = 1'b1;
          wr_spec_d = wr_commit_q;
          base      = wr_commit_q;
          idle_proc = 1'b1;
        end else begin
          we        = 1'b1;
          wdata     = {1'b0, (n_q == 5'd0), noc_to_dev_data};
          wr_spec_d = wr_spec_q + 1'b1;
          if (n_q == 5'd0) begin
            wr_commit_d = wr_spec_q + 1'b1;
            state_d     = S_IDLE;
          end else begin
            count_d = {1'b0, n_q};
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (noc_to_dev_ctl) begin
          abort_d   = 1'b1;
          wr_spec_d = wr_commit_q;
          base      = wr_commit_q;
          idle_proc = 1'b1;
        end else begin
          we        = 1'b1;
          wdata     = {1'b0, (count_q == 6'd1), noc_to_dev_data};
          wr_spec_d = wr_spec_q + 1'b1;
          count_d   = count_q - 6'd1;
          if (count_q == 6'd1) begin
            wr_commit_d = wr_spec_q + 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (noc_to_dev_ctl) begin
          idle_proc = 1'b1;
        end else begin
          count_d = count_q - 6'd1;
          if (count_q == 6'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A command seen mid-frame is handled as if it arrived in IDLE, against the rolled-back pointer
    if (idle_proc) begin
      state_d = S_IDLE;
      if (noc_to_dev_ctl) begin
        if (opcode != 3'd0) begin
          free = DEPTH_W - (base - rd_ptr_q);
          need = (AW+1)'(len) + (AW+1)'(2);
          if (free >= need) begin
            we        = 1'b1;
            waddr     = base[AW-1:0];
            wdata     = {1'b1, 1'b0, noc_to_dev_data};
            wr_spec_d = base + 1'b1;
            n_d       = len;
            state_d   = S_DEST;
          end else begin
            drop_d  = 1'b1;
            count_d = 6'(len) + 6'd1;
            state_d = S_DROP;
          end
        end
      end else begin
        stray_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      n_q         <= '0;
      rd_ptr_q    <= '0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      drop_q      <= 1'b0;
      abort_q     <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      n_q         <= n_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      drop_q      <= drop_d;
      abort_q     <= abort_d;
      stray_q     <= stray_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule
